// File: rtl/uart_responder.sv
// ============================================================================
// uart_responder : byte-wide 8N1 UART answering MMU rdn/wrn strobes on a shared bus
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_responder #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rdn,
  input  logic       uart_wrn,
  inout  wire  [7:0] data_io,
  output logic       uart_dataready,
  output logic       uart_tbre,
  output logic       uart_tsre,
  output logic       txd,
  input  logic       rxd
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] c_half_last = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_FERR  = 3'd4
  } rx_state_e;

  // --------------------------------------------------------------------------
  // Input synchronisers and strobe edge detection
  // --------------------------------------------------------------------------
  logic [1:0] rdn_sync_q;
  logic [1:0] wrn_sync_q;
  logic [1:0] rxd_sync_q;
  logic       rdn_prev_q;
  logic       wrn_prev_q;

  logic       w_rd_rise;
  logic       w_wr_fall;
  logic       w_rxd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdn_sync_q <= 2'b11;
      wrn_sync_q <= 2'b11;
      rxd_sync_q <= 2'b11;
      rdn_prev_q <= 1'b1;
      wrn_prev_q <= 1'b1;
    end else begin
      rdn_sync_q <= {rdn_sync_q[0], uart_rdn};
      wrn_sync_q <= {wrn_sync_q[0], uart_wrn};
      rxd_sync_q <= {rxd_sync_q[0], rxd};
      rdn_prev_q <= rdn_sync_q[1];
      wrn_prev_q <= wrn_sync_q[1];
    end
  end

  assign w_rd_rise = rdn_sync_q[1] & ~rdn_prev_q;
  assign w_wr_fall = ~wrn_sync_q[1] & wrn_prev_q;
  assign w_rxd     = rxd_sync_q[1];

  // --------------------------------------------------------------------------
  // Transmit path
  // --------------------------------------------------------------------------
  tx_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q,   tx_cnt_d;
  logic [2:0]       tx_bit_q,   tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic [7:0]       thr_q,      thr_d;
  logic             txd_q,      txd_d;
  logic             tbre_q,     tbre_d;
  logic             tsre_q,     tsre_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      thr_q      <= '0;
      txd_q      <= 1'b1;
      tbre_q     <= 1'b1;
      tsre_q     <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      thr_q      <= thr_d;
      txd_q      <= txd_d;
      tbre_q     <= tbre_d;
      tsre_q     <= tsre_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    thr_d      = thr_q;
    txd_d      = txd_q;
    tbre_d     = tbre_q;
    tsre_d     = tsre_q;

    // A write while the holding register is full is silently dropped.
    if (w_wr_fall && tbre_q) begin
      thr_d  = data_io;
      tbre_d = 1'b0;
    end

    case (tx_state_q)
      TX_IDLE: begin
        if (!tbre_q) begin
          tx_shift_d = thr_q;
          tbre_d     = 1'b1;
          tsre_d     = 1'b0;
          txd_d      = 1'b0;
          tx_cnt_d   = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == c_bit_last) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          txd_d      = tx_shift_q[0];
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == c_bit_last) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            txd_d      = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_shift_d = tx_shift_q >> 1;
            txd_d      = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == c_bit_last) begin
          tx_cnt_d = '0;
          if (!tbre_q) begin
            tx_shift_d = thr_q;
            tbre_d     = 1'b1;
            txd_d      = 1'b0;
            tx_state_d = TX_START;
          end else if (w_wr_fall) begin
            // Write arriving on the final stop cycle goes straight to the shifter.
            tx_shift_d = data_io;
            tbre_d     = 1'b1;
            txd_d      = 1'b0;
            tx_state_d = TX_START;
          end else begin
            tsre_d     = 1'b1;
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Receive path
  // --------------------------------------------------------------------------
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q,   rx_cnt_d;
  logic [2:0]       rx_bit_q,   rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       rhr_q,      rhr_d;
  logic             dready_q,   dready_d;
  logic             w_rx_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rhr_q      <= '0;
      dready_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rhr_q      <= rhr_d;
      dready_q   <= dready_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rhr_d      = rhr_q;
    w_rx_done  = 1'b0;

    case (rx_state_q)
      RX_IDLE: begin
        if (!w_rxd) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == c_half_last) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = w_rxd ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == c_bit_last) begin
          rx_cnt_d   = '0;
          rx_shift_d = {w_rxd, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == c_bit_last) begin
          rx_cnt_d = '0;
          if (w_rxd) begin
            rhr_d      = rx_shift_q;
            w_rx_done  = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_FERR;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_FERR: begin
        // Hold off until the line returns high so a broken frame cannot retrigger.
        if (w_rxd) begin
          rx_state_d = RX_IDLE;
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
      end
    endcase
  end

  // A byte completing on the same cycle as a read consume keeps dataready set.
  always_comb begin
    dready_d = dready_q;
    if (w_rx_done) begin
      dready_d = 1'b1;
    end else if (w_rd_rise) begin
      dready_d = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign data_io        = uart_rdn ? 8'bzzzz_zzzz : rhr_q;
  assign uart_dataready = dready_q;
  assign uart_tbre      = tbre_q;
  assign uart_tsre      = tsre_q;
  assign txd            = txd_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_responder.sv
// ============================================================================
// tb_uart_responder : directed + randomized self-checking bench for uart_responder
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_responder;

  logic       clk;
  logic       rst_n;
  logic       uart_rdn;
  logic       uart_wrn;
  wire  [7:0] data_io;
  logic       uart_dataready;
  logic       uart_tbre;
  logic       uart_tsre;
  logic       txd;
  logic       rxd;

  logic [7:0] host_d;
  logic       host_oe;
  logic       saw_tbre0;
  logic [7:0] zz;

  int n_cmp;
  int n_err;

  assign data_io = host_oe ? host_d : 8'bzzzz_zzzz;

  uart_responder #(
    .CLK_FREQ (1_000_000),
    .BAUD     (100_000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .uart_rdn       (uart_rdn),
    .uart_wrn       (uart_wrn),
    .data_io        (data_io),
    .uart_dataready (uart_dataready),
    .uart_tbre      (uart_tbre),
    .uart_tsre      (uart_tsre),
    .txd            (txd),
    .rxd            (rxd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Line levels of one 8N1 frame, index 0 = first bit on the wire.
  function automatic logic [9:0] exp_frame(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input logic [7:0] d);
    @(negedge clk);
    host_d   = d;
    host_oe  = 1'b1;
    uart_wrn = 1'b0;
    repeat (4) @(negedge clk);
    uart_wrn = 1'b1;
    repeat (2) @(negedge clk);
    host_oe  = 1'b0;
  endtask

  // Waits for a start bit, then samples each bit at its midpoint.
  task automatic tx_capture(input int nbits, output logic [31:0] bits, output int ok);
    int t;
    t    = 0;
    ok   = 0;
    bits = '0;
    while (txd !== 1'b0 && t < 60) begin
      @(negedge clk);
      if (uart_tbre === 1'b0) saw_tbre0 = 1'b1;
      t++;
    end
    if (txd === 1'b0) begin
      ok = 1;
      repeat (5) @(negedge clk);
      bits[0] = txd;
      for (int i = 1; i < nbits; i++) begin
        repeat (10) @(negedge clk);
        bits[i] = txd;
      end
    end
  endtask

  // Called from the midpoint of the last stop bit.
  task automatic tsre_tail(input string tag);
    repeat (3) @(negedge clk);
    check({tag, "_tsre_busy_in_stop"}, uart_tsre, 1'b0);
    check({tag, "_txd_stop"}, txd, 1'b1);
    repeat (3) @(negedge clk);
    check({tag, "_tsre_idle"}, uart_tsre, 1'b1);
    check({tag, "_tbre_idle"}, uart_tbre, 1'b1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      repeat (10) @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  task automatic host_read(input string tag, input logic [7:0] exp);
    uart_rdn = 1'b0;
    #1;
    check({tag, "_data"}, data_io, exp);
    @(negedge clk);
    uart_rdn = 1'b1;
    repeat (4) @(negedge clk);
    check({tag, "_consumed"}, uart_dataready, 1'b0);
    check({tag, "_bus_z"}, data_io, zz);
  endtask

  initial begin
    logic [31:0] bits;
    int          ok;
    logic [7:0]  r;
    logic        low_seen;

    n_cmp    = 0;
    n_err    = 0;
    zz       = 8'bzzzz_zzzz;
    rst_n    = 1'b0;
    uart_rdn = 1'b1;
    uart_wrn = 1'b1;
    rxd      = 1'b1;
    host_oe  = 1'b0;
    host_d   = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1'b1);
    check("rst_tbre", uart_tbre, 1'b1);
    check("rst_tsre", uart_tsre, 1'b1);
    check("rst_dready", uart_dataready, 1'b0);
    check("rst_bus_z", data_io, zz);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte 0xA5
    saw_tbre0 = 1'b0;
    fork
      host_write(8'hA5);
      tx_capture(10, bits, ok);
    join
    check("a5_start_seen", ok, 1);
    check("a5_tbre_dip", saw_tbre0, 1'b1);
    check("a5_bits", bits, {22'd0, exp_frame(8'hA5)});
    tsre_tail("a5");
    repeat (5) @(negedge clk);

    // Back-to-back 0x55, 0x0F; a third write while THR is full is dropped
    fork
      begin
        host_write(8'h55);
        repeat (12) @(negedge clk);
        host_write(8'h0F);
        repeat (15) @(negedge clk);
        check("b2b_thr_full", uart_tbre, 1'b0);
        host_write(8'hC3);
      end
      tx_capture(20, bits, ok);
    join
    check("b2b_start_seen", ok, 1);
    check("b2b_bits", bits, {12'd0, exp_frame(8'h0F), exp_frame(8'h55)});
    tsre_tail("b2b");
    low_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) low_seen = 1'b1;
    end
    check("b2b_dropped_not_sent", low_seen, 1'b0);

    // Random transmit bytes
    for (int k = 0; k < 3; k++) begin
      r = 8'($urandom_range(0, 255));
      fork
        host_write(r);
        tx_capture(10, bits, ok);
      join
      check("rnd_tx_bits", bits, {22'd0, exp_frame(r)});
      tsre_tail("rnd_tx");
      repeat (5) @(negedge clk);
    end

    // Receive 0x3C and read it back
    send_frame(8'h3C, 1'b1);
    check("rx3c_dready", uart_dataready, 1'b1);
    check("rx3c_bus_z_idle", data_io, zz);
    host_read("rx3c", 8'h3C);

    // Short low glitch must not start a frame
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (120) @(negedge clk);
    check("glitch_no_frame", uart_dataready, 1'b0);

    // Framing error: stop bit low
    send_frame(8'($urandom_range(0, 255)), 1'b0);
    repeat (20) @(negedge clk);
    check("ferr_no_byte", uart_dataready, 1'b0);

    // Overrun: 0x22 replaces unread 0x11
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    check("ovr_dready", uart_dataready, 1'b1);
    uart_rdn = 1'b0;
    #1;
    check("ovr_rhr", data_io, 8'h22);
    @(negedge clk);

    // Read consume coinciding with 0x33 completion: new byte wins
    fork
      send_frame(8'h33, 1'b1);
      begin
        repeat (95) @(negedge clk);
        uart_rdn = 1'b1;
      end
    join
    repeat (2) @(negedge clk);
    check("same_cycle_dready", uart_dataready, 1'b1);
    host_read("same_cycle", 8'h33);

    // Random receive bytes
    for (int k = 0; k < 3; k++) begin
      r = 8'($urandom_range(0, 255));
      send_frame(r, 1'b1);
      check("rnd_rx_dready", uart_dataready, 1'b1);
      host_read("rnd_rx", r);
    end

    // Asynchronous reset in the middle of a transmit with an unread byte held
    send_frame(8'($urandom_range(0, 255)), 1'b1);
    fork
      host_write(8'($urandom_range(0, 255)));
      repeat (30) @(negedge clk);
    join
    check("pre_rst_busy", uart_tsre, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_txd", txd, 1'b1);
    check("arst_tbre", uart_tbre, 1'b1);
    check("arst_tsre", uart_tsre, 1'b1);
    check("arst_dready", uart_dataready, 1'b0);
    check("arst_bus_z", data_io, zz);
    @(negedge clk);
    rst_n = 1'b1;
    low_seen = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) low_seen = 1'b1;
    end
    check("arst_frame_aborted", low_seen, 1'b0);
    check("arst_tsre_after", uart_tsre, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
